// File: rtl/adc_serial_tx.sv
// Emulates the two-channel, two-lane serial ADC output (DCO, FR, D0/D1 per channel)
// from parallel samples; used as the far end of the ADC receive path in loopback builds.
module adc_serial_tx #(
    parameter int                    DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] PATTERN1   = DATA_WIDTH'(16'hA5C3),
    parameter logic [DATA_WIDTH-1:0] PATTERN2   = DATA_WIDTH'(16'h3C5A)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  pattern_en,
    input  logic [DATA_WIDTH-1:0] ch1_data,
    input  logic [DATA_WIDTH-1:0] ch2_data,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  dco,
    output logic                  fr,
    output logic                  d10,
    output logic                  d11,
    output logic                  d20,
    output logic                  d21,
    output logic                  underrun,
    output logic [15:0]           underrun_cnt
);

    localparam int FPL = DATA_WIDTH / 2;
    localparam int CW  = (FPL > 1) ? $clog2(FPL) : 1;
    localparam logic [CW-1:0] LAST = CW'(FPL - 1);
    localparam logic [CW-1:0] HALF = CW'(FPL / 2);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           bit_cnt;
    logic [DATA_WIDTH-1:0]   sh1, sh2, hold1, hold2;
    logic [DATA_WIDTH-1:0]   ld1, ld2;
    logic                    last, take, empty;

    assign last = (state == RUN) && (bit_cnt == LAST);

    // State register; bit_cnt names the bit currently on the lanes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (data_ready || last || state == IDLE)
                bit_cnt <= '0;
            else
                bit_cnt <= bit_cnt + CW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = RUN;
            RUN:     if (last && !en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Load-slot decode: pattern beats data beats the hold (underrun) path.
    always_comb begin
        data_ready = 1'b0;
        case (state)
            IDLE:    data_ready = en;
            RUN:     data_ready = en && last;
            default: data_ready = 1'b0;
        endcase
        ld1   = hold1;
        ld2   = hold2;
        take  = 1'b0;
        empty = 1'b0;
        if (pattern_en) begin
            ld1 = PATTERN1;
            ld2 = PATTERN2;
        end else if (data_valid) begin
            ld1  = ch1_data;
            ld2  = ch2_data;
            take = data_ready;
        end else begin
            empty = data_ready;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh1 <= '0;
            sh2 <= '0;
            fr  <= 1'b0;
            dco <= 1'b0;
        end else if (data_ready) begin
            sh1 <= ld1;
            sh2 <= ld2;
            fr  <= 1'b1;
            dco <= 1'b1;
        end else if (state == RUN && !last) begin
            sh1 <= sh1 << 2;
            sh2 <= sh2 << 2;
            fr  <= (bit_cnt + CW'(1)) < HALF;
            dco <= ~dco;
        end else begin
            sh1 <= '0;
            sh2 <= '0;
            fr  <= 1'b0;
            dco <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold1        <= '0;
            hold2        <= '0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            if (take) begin
                hold1 <= ch1_data;
                hold2 <= ch2_data;
            end
            underrun <= empty;
            if (empty && underrun_cnt != 16'hFFFF)
                underrun_cnt <= underrun_cnt + 16'd1;
        end
    end

    // Lanes come straight from the top of the shift registers (flop outputs).
    assign d11 = sh1[DATA_WIDTH-1];
    assign d10 = sh1[DATA_WIDTH-2];
    assign d21 = sh2[DATA_WIDTH-1];
    assign d20 = sh2[DATA_WIDTH-2];

endmodule

// File: doc/adc_serial_tx.md
# adc_serial_tx

Synthesizable transmitter that emulates the two-channel, two-lane serial LVDS output of the board ADCs (DCO, FR and per-channel D0/D1 lanes), driven from parallel 16-bit samples. It is the far end of the ADC receive path: in loopback builds its outputs feed the ADC receiver through the differential output buffers, so the capture and deserialization logic can be exercised without an ADC. All outputs are single-ended and registered; differential buffering and any DDR retiming sit outside this block.

## Interface
- DATA_WIDTH, 16, sample width per channel; must be even.
- PATTERN1, 16'hA5C3, fixed channel-1 word in pattern mode.
- PATTERN2, 16'h3C5A, fixed channel-2 word in pattern mode.
- clk  in  1  bit-rate clock; one lane bit per cycle.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  transmit enable.
- pattern_en  in  1  send PATTERN1/PATTERN2 instead of input data; sampled at load slots.
- ch1_data  in  DATA_WIDTH  channel-1 sample.
- ch2_data  in  DATA_WIDTH  channel-2 sample.
- data_valid  in  1  ch1_data/ch2_data are valid.
- data_ready  out  1  load slot; a sample transfers when data_valid && data_ready.
- dco  out  1  emulated data clock.
- fr  out  1  emulated frame signal.
- d10, d11  out  1  channel-1 lanes 0 and 1.
- d20, d21  out  1  channel-2 lanes 0 and 1.
- underrun  out  1  one-cycle pulse: load slot with no valid data.
- underrun_cnt  out  16  saturating count of underruns.

## Operation
- One clock; reset is asynchronous and active-low. On reset: state IDLE, bit_cnt=0, shift and hold registers 0; all outputs 0, including underrun_cnt.
- FPL = DATA_WIDTH/2 bits per lane per frame (8 by default). bit_cnt runs 0..FPL-1.
- States are IDLE and RUN.
- IDLE:
  - dco, fr and all lanes are held at 0.
  - data_ready = en (combinational).
  - On the first cycle with en=1, a load slot occurs and the next state is RUN with bit_cnt=0.
- RUN:
  - bit_cnt increments each cycle and wraps FPL-1 -> 0.
  - data_ready = en && (bit_cnt == FPL-1).
  - If en=0 at bit_cnt==FPL-1, the block finishes the current frame, performs no load, and returns to IDLE. Deasserting en mid-frame never truncates a frame.
- Load slot (data_ready=1), priority order:
  - pattern_en=1: load PATTERN1/PATTERN2. data_valid is ignored, no transfer occurs and no underrun is flagged.
  - data_valid=1: load ch1_data/ch2_data, and also copy them into the hold registers.
  - Otherwise: reload the hold registers (last sample; 0 after reset), pulse underrun for one cycle, and increment underrun_cnt, saturating at 16'hFFFF.
- Lane mapping, MSB first:
  - d11/d21 carry bits DW-1, DW-3, …, 1.
  - d10/d20 carry bits DW-2, DW-4, …, 0.
  - Each cycle both shift registers shift by 2.
- fr = 1 for bit_cnt 0..FPL/2-1 and 0 for FPL/2..FPL-1 (50% duty, one period per frame).
- dco = 1 at even bit_cnt and 0 at odd bit_cnt (toggles every cycle in RUN).
- All outputs except data_ready are registered.

## Timing
- Latency: a transfer at edge N puts bits DW-1/DW-2 on the lanes with fr=1, dco=1 in cycle N+1. The sample's last bits appear in cycle N+FPL.
- Back-to-back frames have no gap. The next load slot coincides with the last bit of the current frame.
- Sustained throughput is one sample pair per FPL cycles.
- The last bit of a frame is followed by IDLE zeros on all outputs when en was 0 at that slot.
- underrun is asserted in the cycle after the empty load slot, aligned with the first bit of the repeated frame.
- If rst_n asserts mid-frame, all outputs go to 0 immediately. After release, the block waits in IDLE for en.

## Test plan
- Load sample: reset, en=1, valid, ch1=16'h8001, ch2=16'h7FFE.
  - Lanes over the 8 bits: d11=1,0,0,0,0,0,0,0; d10=0,0,0,0,0,0,0,1; d21=0,1,1,1,1,1,1,1; d20=1,1,1,1,1,1,1,0.
  - fr=1,1,1,1,0,0,0,0; dco toggles 1,0,…
- Streaming: valid held high with incrementing samples 0x0000..0x00FF.
  - data_ready is high exactly every 8th cycle.
  - No gaps, no underrun.
  - A receiver model reconstructs all 256 samples in order.
- Underrun: send 16'h1234, then drop valid for 2 slots.
  - 16'h1234 is sent 3 times.
  - underrun pulses twice; underrun_cnt=2.
- Pattern mode: pattern_en=1 with valid=1 and ch1=16'h0000.
  - Lanes carry 16'hA5C3/16'h3C5A.
  - underrun_cnt does not change.
  - The hold registers are unchanged, confirmed by a later underrun repeating the last real sample.
- Enable: deassert en at bit_cnt=2.
  - The frame completes through bit_cnt=7, then all outputs are 0.
  - Re-asserting en starts a new frame one cycle later at bit_cnt=0.
- Reset mid-frame: assert rst_n at bit_cnt=5.
  - All outputs and underrun_cnt read 0 immediately.
  - Underrun after release repeats 16'h0000.
